glyph_fetcher: RTL and testbench
================================

Name: glyph_fetcher

Overview:
- Responder side of the character-display interface. Consumes the fetch request `readEn` and the glyph coordinates `rowCnt`/`colCnt`, and returns the `bitDisp` pixel bit.
- Loads a 16x8 glyph bitmap from the font ROM into a shadow buffer using a req/ack handshake, then swaps it into an active buffer.
- Serves one registered bit per clock from the active buffer.
- Sits between the character display stage and the font ROM.

Parameters:
- ROWS, 16, glyph rows; rowCnt indexes 0..ROWS-1.
- COLS, 8, glyph columns; equals romData width.
- TIMEOUT, 15, maximum cycles waiting for romAck before the fetch is aborted.

Ports:
- clock  input  1  system pixel clock.
- reset  input  1  asynchronous, active-low reset.
- readEn  input  1  fetch request pulse from the display stage.
- charCode  input  8  character code, sampled when readEn=1.
- rowCnt  input  4  glyph row being displayed.
- colCnt  input  3  glyph column being displayed.
- romReq  output  1  font ROM request; held until ack or timeout.
- romAddr  output  12  {code[7:0], row[3:0]}; stable while romReq=1.
- romAck  input  1  ROM data valid; single-cycle pulse.
- romData  input  8  glyph row bits; bit 7 is the leftmost pixel.
- bitDisp  output  1  registered pixel bit for (rowCnt, colCnt).
- glyphValid  output  1  active buffer holds a complete glyph.
- fetchErr  output  1  one-cycle pulse when a fetch is aborted on timeout.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - romReq=0, romAddr=0, bitDisp=0, glyphValid=0, fetchErr=0.
  - Both buffers cleared to 0; pending=0; timeout counter=0.
  - A reset asserted mid-fetch aborts the fetch with no swap. The first request after release must be a fresh readEn.
- FSM states: IDLE, REQ, WAIT, SWAP.
  - IDLE, readEn=1: latch code<=charCode, row<=0, go to REQ.
  - REQ: drive romReq=1 and romAddr={code,row}, clear the timeout counter, go to WAIT.
  - WAIT, romAck=1:
    - shadow[row]<=romData; romReq<=0.
    - If row==ROWS-1, go to SWAP. Otherwise row<=row+1 and go to REQ.
    - The address therefore changes only while romReq is low.
  - WAIT, no ack: increment the counter. When counter==TIMEOUT, set romReq<=0, pulse fetchErr for one cycle, discard shadow, leave the active buffer and glyphValid untouched, go to IDLE.
  - SWAP (one cycle):
    - active<=shadow; glyphValid<=1.
    - If pending=1, clear pending, latch code<=pendCode, row<=0, go to REQ. Otherwise go to IDLE.
- Request collisions:
  - readEn in REQ, WAIT or SWAP: pending<=1, pendCode<=charCode. The latest request overwrites earlier ones and the current fetch is not restarted.
  - readEn in the same cycle as the timeout: the pending request is honoured; IDLE is skipped and the FSM enters REQ next cycle.
- Fetch latency, with ack one cycle after romReq rises: 3 cycles per row. A full glyph takes 48 cycles plus one SWAP cycle from the readEn pulse.
- Pixel path:
  - bitDisp <= glyphValid ? active[rowCnt][7-colCnt] : 0, one clock of latency.
  - rowCnt >= ROWS gives bitDisp=0.
  - The swap and a read in the same cycle: the read uses the old active contents, and the new contents appear the next cycle.
- romAck outside WAIT is ignored.
- romData is sampled only on a WAIT-state ack.

Test Plan:
- Reset release, then rowCnt=0..15 and colCnt=0..7 swept with no fetch: bitDisp=0 throughout, glyphValid=0, romReq=0.
- readEn with charCode=8'h41, ROM acking one cycle after each req with romData=8'hA5 for every row:
  - romAddr goes 12'h410..12'h41F, each stable while romReq=1.
  - glyphValid rises 49 cycles after readEn.
  - Then rowCnt=3, colCnt=0 gives bitDisp=1, and colCnt=1 gives bitDisp=0, each one cycle after the inputs are applied.
- ROM never acks at row 5 of charCode=8'h42:
  - romReq drops after 15 WAIT cycles and fetchErr pulses exactly once.
  - The active buffer still returns the 8'h41 glyph; glyphValid stays 1.
- readEn with 8'h43 during a fetch, then readEn with 8'h44 during the same fetch:
  - After the SWAP the next request is at romAddr=12'h440.
  - No 12'h43x address is ever issued.
- reset=0 asserted while in WAIT at row 7:
  - All outputs are 0 immediately (asynchronously).
  - After release, no romReq until a new readEn.
- Swap coincident with a read at rowCnt=0, colCnt=0, old bit 0 and new bit 1: bitDisp=0 that cycle, then 1 on the following cycle.

Source files
------------

// File: rtl/glyph_fetcher.sv
// Glyph fetcher: pulls a ROWS x COLS glyph from the font ROM into a shadow buffer
// using a req/ack handshake, swaps it into an active buffer and serves one pixel bit per clock.
module glyph_fetcher #(
    parameter int ROWS    = 16,
    parameter int COLS    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        readEn,
    input  logic [7:0]  charCode,
    input  logic [3:0]  rowCnt,
    input  logic [2:0]  colCnt,
    output logic        romReq,
    output logic [11:0] romAddr,
    input  logic        romAck,
    input  logic [7:0]  romData,
    output logic        bitDisp,
    output logic        glyphValid,
    output logic        fetchErr
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] SWAP = 2'd3;

    localparam logic [3:0]    LAST_ROW = 4'(ROWS - 1);
    localparam logic [2:0]    LAST_COL = 3'(COLS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);

    logic [1:0]                      state_q, state_d;
    logic [7:0]                      code_q, code_d;
    logic [3:0]                      row_q, row_d;
    logic                            pending_q, pending_d;
    logic [7:0]                      pend_code_q, pend_code_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            rom_req_q, rom_req_d;
    logic [11:0]                     rom_addr_q, rom_addr_d;
    logic [ROWS-1:0][COLS-1:0]       shadow_q, shadow_d;
    logic [ROWS-1:0][COLS-1:0]       active_q, active_d;
    logic                            glyph_valid_q, glyph_valid_d;
    logic                            fetch_err_q, fetch_err_d;
    logic                            bit_disp_q, bit_disp_d;
    logic                            took_now;

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        row_d         = row_q;
        pending_d     = pending_q;
        pend_code_d   = pend_code_q;
        cnt_d         = cnt_q;
        rom_req_d     = rom_req_q;
        rom_addr_d    = rom_addr_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        glyph_valid_d = glyph_valid_q;
        fetch_err_d   = 1'b0;
        took_now      = 1'b0;

        case (state_q)
            IDLE: begin
                if (readEn) begin
                    code_d   = charCode;
                    row_d    = '0;
                    state_d  = REQ;
                    took_now = 1'b1;
                end else if (pending_q) begin
                    // A request that landed during the SWAP cycle is serviced here.
                    code_d    = pend_code_q;
                    row_d     = '0;
                    pending_d = 1'b0;
                    state_d   = REQ;
                end
            end
            REQ: begin
                rom_req_d  = 1'b1;
                rom_addr_d = {code_q, row_q};
                cnt_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (romAck) begin
                    shadow_d[row_q] = romData;
                    rom_req_d       = 1'b0;
                    if (row_q == LAST_ROW) begin
                        state_d = SWAP;
                    end else begin
                        row_d   = row_q + 4'd1;
                        state_d = REQ;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    rom_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    shadow_d    = '0;
                    if (readEn || pending_q) begin
                        // The newest request wins and goes straight to REQ.
                        code_d    = readEn ? charCode : pend_code_q;
                        row_d     = '0;
                        pending_d = 1'b0;
                        state_d   = REQ;
                        took_now  = readEn;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                active_d      = shadow_q;
                glyph_valid_d = 1'b1;
                if (pending_q) begin
                    code_d    = pend_code_q;
                    row_d     = '0;
                    pending_d = 1'b0;
                    state_d   = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        // Capture comes after the FSM so a fresh request overrides a pending one just consumed.
        if (readEn && (state_q != IDLE) && !took_now) begin
            pending_d   = 1'b1;
            pend_code_d = charCode;
        end

        bit_disp_d = 1'b0;
        if (glyph_valid_q && (32'(rowCnt) < ROWS))
            bit_disp_d = active_q[rowCnt][LAST_COL - colCnt];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            code_q        <= '0;
            row_q         <= '0;
            pending_q     <= 1'b0;
            pend_code_q   <= '0;
            cnt_q         <= '0;
            rom_req_q     <= 1'b0;
            rom_addr_q    <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            glyph_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            bit_disp_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            row_q         <= row_d;
            pending_q     <= pending_d;
            pend_code_q   <= pend_code_d;
            cnt_q         <= cnt_d;
            rom_req_q     <= rom_req_d;
            rom_addr_q    <= rom_addr_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            glyph_valid_q <= glyph_valid_d;
            fetch_err_q   <= fetch_err_d;
            bit_disp_q    <= bit_disp_d;
        end
    end

    assign romReq     = rom_req_q;
    assign romAddr    = rom_addr_q;
    assign bitDisp    = bit_disp_q;
    assign glyphValid = glyph_valid_q;
    assign fetchErr   = fetch_err_q;
endmodule

// File: tb/tb_glyph_fetcher.sv
// Self-checking bench for glyph_fetcher: ROM responder, vector table, corner sequences
// and randomized fetch/read traffic checked against a glyph-level reference model.
module tb_glyph_fetcher;
    logic        clock;
    logic        reset;
    logic        readEn;
    logic [7:0]  charCode;
    logic [3:0]  rowCnt;
    logic [2:0]  colCnt;
    logic        romReq;
    logic [11:0] romAddr;
    logic        romAck;
    logic [7:0]  romData;
    logic        bitDisp;
    logic        glyphValid;
    logic        fetchErr;

    int checks;
    int fails;

    logic [11:0] addr_log[$];
    logic        stall_en;
    logic [11:0] stall_addr;
    logic [7:0]  model_act[16];
    logic        model_valid;

    typedef struct {
        logic [3:0] r;
        logic [2:0] c;
        logic       exp;
    } vec_t;
    vec_t tbl[8];

    glyph_fetcher dut (
        .clock(clock), .reset(reset), .readEn(readEn), .charCode(charCode),
        .rowCnt(rowCnt), .colCnt(colCnt), .romReq(romReq), .romAddr(romAddr),
        .romAck(romAck), .romData(romData), .bitDisp(bitDisp),
        .glyphValid(glyphValid), .fetchErr(fetchErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] rom_byte(input logic [7:0] code, input logic [3:0] row);
        if (code == 8'h41) return 8'hA5;
        return code ^ {row, ~row};
    endfunction

    assign romData = rom_byte(romAddr[11:4], romAddr[3:0]);

    function automatic logic model_bit(input logic [3:0] r, input logic [2:0] c);
        logic [7:0] b;
        b = model_act[r];
        return model_valid ? b[3'd7 - c] : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] r, input logic [2:0] c, input logic exp, input string name);
        @(negedge clock);
        rowCnt = r;
        colCnt = c;
        @(negedge clock);
        chk(name, 32'(bitDisp), 32'(exp));
    endtask

    task automatic req(input logic [7:0] code);
        @(negedge clock);
        readEn   = 1'b1;
        charCode = code;
        @(negedge clock);
        readEn   = 1'b0;
    endtask

    task automatic wait_log(input int n, input int budget);
        int t;
        t = 0;
        while (addr_log.size() < n && t < budget) begin
            @(negedge clock);
            t++;
        end
        chk("fetch_progress", 32'(addr_log.size() >= n), 1);
    endtask

    task automatic wait_addr(input logic [11:0] a, input int budget);
        int t;
        t = 0;
        while (!(romReq && romAddr == a) && t < budget) begin
            @(negedge clock);
            t++;
        end
        chk("reach_addr", 32'(romReq && romAddr == a), 1);
    endtask

    task automatic set_model(input logic [7:0] code);
        for (int r = 0; r < 16; r++) model_act[r] = rom_byte(code, 4'(r));
        model_valid = 1'b1;
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < 8; i++) rd(tbl[i].r, tbl[i].c, tbl[i].exp, name);
    endtask

    // ROM responder: ack on the second cycle of each request unless the address is stalled.
    initial begin
        int age;
        logic [11:0] held;
        age    = 0;
        held   = '0;
        romAck = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset || !romReq) begin
                age    = 0;
                romAck = 1'b0;
            end else begin
                age++;
                if (age == 1) begin
                    held = romAddr;
                    addr_log.push_back(romAddr);
                end else begin
                    chk("addr_stable", 32'(romAddr), 32'(held));
                end
                romAck = (age == 2) && !(stall_en && romAddr == stall_addr);
            end
        end
    end

    initial begin
        int cyc, req_hi, errs, hits;
        logic [7:0] code;
        logic [3:0] r;
        logic [2:0] c;

        checks = 0; fails = 0;
        reset = 1'b0; readEn = 1'b0; charCode = '0; rowCnt = '0; colCnt = '0;
        stall_en = 1'b0; stall_addr = '0; model_valid = 1'b0;
        for (int i = 0; i < 16; i++) model_act[i] = '0;

        // 0xA5 = 1010_0101, leftmost pixel is bit 7
        tbl[0] = '{4'd3,  3'd0, 1'b1};
        tbl[1] = '{4'd3,  3'd1, 1'b0};
        tbl[2] = '{4'd0,  3'd2, 1'b1};
        tbl[3] = '{4'd15, 3'd3, 1'b0};
        tbl[4] = '{4'd7,  3'd4, 1'b0};
        tbl[5] = '{4'd9,  3'd5, 1'b1};
        tbl[6] = '{4'd12, 3'd6, 1'b0};
        tbl[7] = '{4'd15, 3'd7, 1'b1};

        repeat (3) @(negedge clock);
        chk("rst_romReq", 32'(romReq), 0);
        chk("rst_romAddr", 32'(romAddr), 0);
        chk("rst_bitDisp", 32'(bitDisp), 0);
        chk("rst_glyphValid", 32'(glyphValid), 0);
        chk("rst_fetchErr", 32'(fetchErr), 0);
        reset = 1'b1;

        for (int ri = 0; ri < 16; ri++)
            for (int ci = 0; ci < 8; ci++) begin
                rd(4'(ri), 3'(ci), 1'b0, "idle_sweep");
                chk("idle_valid", 32'(glyphValid), 0);
                chk("idle_req", 32'(romReq), 0);
            end

        // first glyph 0x41, latency and address sequence
        addr_log.delete();
        req(8'h41);
        cyc = 0;
        while (!glyphValid && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        chk("valid_latency", 32'(cyc), 49);
        chk("addr_count", 32'(addr_log.size()), 16);
        for (int i = 0; i < 16; i++)
            chk("addr_seq", (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hFFFF, 32'h410 + 32'(i));
        set_model(8'h41);
        run_table("tbl_41");

        // timeout on row 5 of 0x42
        stall_en = 1'b1; stall_addr = 12'h425;
        addr_log.delete();
        req(8'h42);
        req_hi = 0; errs = 0;
        for (int t = 0; t < 120; t++) begin
            @(negedge clock);
            if (romReq && romAddr == 12'h425) req_hi++;
            if (fetchErr) errs++;
        end
        chk("timeout_req_cycles", 32'(req_hi), 15);
        chk("timeout_err_pulses", 32'(errs), 1);
        chk("timeout_valid", 32'(glyphValid), 1);
        chk("timeout_req_low", 32'(romReq), 0);
        chk("timeout_last_addr", (addr_log.size() > 0) ? 32'(addr_log[addr_log.size()-1]) : 0, 32'h425);
        stall_en = 1'b0;
        run_table("tbl_after_abort");

        // collisions: 0x43 then 0x44 during the 0x45 fetch
        addr_log.delete();
        req(8'h45);
        repeat (10) @(negedge clock);
        req(8'h43);
        repeat (10) @(negedge clock);
        req(8'h44);
        wait_log(32, 400);
        repeat (8) @(negedge clock);
        chk("coll_count", 32'(addr_log.size()), 32);
        chk("coll_last_45", (addr_log.size() > 15) ? 32'(addr_log[15]) : 0, 32'h45F);
        chk("coll_next_440", (addr_log.size() > 16) ? 32'(addr_log[16]) : 0, 32'h440);
        hits = 0;
        foreach (addr_log[i]) if (addr_log[i][11:4] == 8'h43) hits++;
        chk("coll_no_43", 32'(hits), 0);
        set_model(8'h44);
        for (int ri = 0; ri < 16; ri += 3) rd(4'(ri), 3'(ri % 8), model_bit(4'(ri), 3'(ri % 8)), "coll_read");

        // swap coincident with a read at (0,0): 0x44 row 0 bit7=0, 0x41 row 0 bit7=1
        @(negedge clock);
        rowCnt = 4'd0; colCnt = 3'd0;
        addr_log.delete();
        req(8'h41);
        wait_addr(12'h41F, 200);
        @(negedge clock);
        @(negedge clock);
        chk("pre_swap", 32'(bitDisp), 0);
        @(negedge clock);
        chk("swap_cycle_old", 32'(bitDisp), 0);
        @(negedge clock);
        chk("after_swap_new", 32'(bitDisp), 1);
        set_model(8'h41);

        // async reset while waiting on row 7
        addr_log.delete();
        req(8'h46);
        wait_addr(12'h467, 200);
        #2 reset = 1'b0;
        #1;
        chk("arst_romReq", 32'(romReq), 0);
        chk("arst_romAddr", 32'(romAddr), 0);
        chk("arst_bitDisp", 32'(bitDisp), 0);
        chk("arst_glyphValid", 32'(glyphValid), 0);
        chk("arst_fetchErr", 32'(fetchErr), 0);
        model_valid = 1'b0;
        for (int i = 0; i < 16; i++) model_act[i] = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        req_hi = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            if (romReq) req_hi++;
        end
        chk("post_rst_no_req", 32'(req_hi), 0);
        rd(4'd3, 3'd0, model_bit(4'd3, 3'd0), "post_rst_read");

        // randomized fetches and reads against the model
        for (int it = 0; it < 6; it++) begin
            code = 8'($urandom_range(8'h50, 8'hFF));
            addr_log.delete();
            req(code);
            wait_log(16, 200);
            repeat (6) @(negedge clock);
            set_model(code);
            chk("rand_valid", 32'(glyphValid), 1);
            for (int k = 0; k < 12; k++) begin
                r = 4'($urandom_range(0, 15));
                c = 3'($urandom_range(0, 7));
                rd(r, c, model_bit(r, c), "rand_read");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
